// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side controller for fifo_sync. Drains the FIFO through its
//   rd_en/dout/empty port and presents the words as a valid/ready stream.
//   A 3-entry output buffer absorbs the FIFO's one-cycle read latency and
//   downstream back-pressure.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   enable      permits new FIFO reads
//   flush       one-cycle pulse; discards buffered and in-flight words
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  registered FIFO read strobe
//   m_valid     output word available
//   m_ready     consumer accepts the word
//   m_data      output word (buffer head)
//   words_out   completed output handshakes, wraps modulo 2^CNT_W
//   busy        high when not in IDLE
module fifo_rd_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] words_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             rd_en_q, rd_en_d;
  logic [1:0]       rd_ptr_q, wr_ptr_q;
  logic [WIDTH-1:0] mem_q [3];
  logic [CNT_W-1:0] cnt_q;
  logic             pop;
  logic             capture;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = mem_q[rd_ptr_q];
  assign fifo_rd_en = rd_en_q;
  assign words_out  = cnt_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    pop     = m_valid && m_ready;
    capture = inflight_q;

    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (capture && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!capture && pop) begin
      occ_d = occ_q - 2'd1;
    end

    // A read issued now lands one cycle later; dropping it here on flush
    // is what discards the word still travelling out of the FIFO.
    inflight_d = rd_en_q && !flush;

    // Issue decision uses next-cycle occupancy so that words buffered,
    // landing and newly requested never exceed the 3 buffer slots; this
    // keeps m_ready out of any combinational path to fifo_rd_en.
    rd_en_d = (state_q == RUN) && enable && !flush && !fifo_empty &&
              (({1'b0, occ_d} + {2'b00, inflight_d}) < 3'd3);

    state_d = state_q;
    unique case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN:   if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if (!inflight_q && (occ_q == 2'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = enable ? RUN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      rd_en_q    <= rd_en_d;
      if (flush) begin
        // Handshake and landing word in the flush cycle are both dropped.
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (capture) begin
          mem_q[wr_ptr_q] <= fifo_dout;
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
        if (pop) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
          cnt_q    <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Directed bench for fifo_rd_stream with a behavioural FIFO model. A
//   second instance with CNT_W=4 shares all inputs and shadows the first.
module tb_fifo_rd_stream;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             flush = 1'b0;
  logic             m_ready = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_rd_en, m_valid, busy;
  logic [WIDTH-1:0] m_data;
  logic [15:0]      words_out;
  logic             rd_en4, valid4, busy4;
  logic [WIDTH-1:0] data4;
  logic [3:0]       words4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] rx_q[$];
  logic [WIDTH-1:0] stage_d = '0;
  logic             stage_v = 1'b0;
  int               rd_count = 0;
  int               rd_viol = 0;
  int               shadow_diff = 0;
  bit               rnd_mode = 1'b0;
  int               wr_left = 0;
  logic [WIDTH-1:0] wr_val = '0;
  logic [3:0]       w4_prev = '0;
  bit               wrap_seen = 1'b0;

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .words_out(words_out), .busy(busy)
  );

  fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(rd_en4),
    .m_valid(valid4), .m_ready(m_ready), .m_data(data4),
    .words_out(words4), .busy(busy4)
  );

  always #5 clk = ~clk;

  // FIFO model: the read is taken on the edge where fifo_rd_en rises, the
  // empty flag updates with it, and the word appears on dout one cycle later.
  always @(posedge clk) begin
    #1;
    if (stage_v) fifo_dout = stage_d;
    stage_v = 1'b0;
    if (fifo_rd_en) begin
      if (fq.size() == 0) begin
        rd_viol++;
      end else begin
        stage_d = fq.pop_front();
        stage_v = 1'b1;
        rd_count++;
      end
    end
    fifo_empty = (fq.size() == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    if (rnd_mode) m_ready = 1'($urandom_range(0, 1));
    if (wr_left > 0 && $urandom_range(0, 3) != 0) begin
      fq.push_back(wr_val);
      wr_val  = wr_val + 8'd1;
      wr_left = wr_left - 1;
    end
    if (m_valid && m_ready && reset && !flush) rx_q.push_back(m_data);
    if (rd_en4 !== fifo_rd_en || valid4 !== m_valid || data4 !== m_data ||
        busy4 !== busy) shadow_diff++;
    @(negedge clk);
    if (w4_prev == 4'd15 && words4 == 4'd0) wrap_seen = 1'b1;
    w4_prev = words4;
  endtask

  task automatic run_until(input string tag, input int n, input int budget, output int used);
    used = 0;
    while (rx_q.size() < n && used < budget) begin
      step();
      used++;
    end
    check({tag, " word count"}, rx_q.size(), n);
  endtask

  task automatic push_seq(input logic [WIDTH-1:0] first, input int n);
    logic [WIDTH-1:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      fq.push_back(v);
      v = v + 8'd1;
    end
  endtask

  task automatic check_rx(input string tag, input logic [WIDTH-1:0] first, input int n);
    logic [WIDTH-1:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) check($sformatf("%s word %0d", tag, i), rx_q[i], v);
      else check($sformatf("%s word %0d missing", tag, i), 0, 1);
      v = v + 8'd1;
    end
  endtask

  initial begin
    int used;
    int rd0;
    logic [15:0] wo0;

    @(negedge clk);
    repeat (3) step();
    check("reset rd_en", fifo_rd_en, 0);
    check("reset m_valid", m_valid, 0);
    check("reset m_data", m_data, 0);
    check("reset words_out", words_out, 0);
    check("reset busy", busy, 0);
    reset = 1'b1;

    // Test 1: 5 words, m_ready held high, latency and drain to IDLE
    push_seq(8'h11, 5);
    repeat (2) step();
    m_ready = 1'b1;
    rd0 = rd_count;
    enable = 1'b1;
    step();
    check("t1 busy after enable", busy, 1);
    check("t1 rd_en edge0", fifo_rd_en, 0);
    step();
    check("t1 rd_en edge1", fifo_rd_en, 1);
    check("t1 m_valid edge1", m_valid, 0);
    step();
    check("t1 m_valid edge2", m_valid, 0);
    step();
    check("t1 m_valid edge3", m_valid, 1);
    check("t1 m_data edge3", m_data, 8'h11);
    run_until("t1", 5, 30, used);
    check_rx("t1", 8'h11, 5);
    repeat (2) step();
    check("t1 words_out", words_out, 5);
    check("t1 reads", rd_count - rd0, 5);
    enable = 1'b0;
    step();
    check("t1 busy in DRAIN", busy, 1);
    step();
    check("t1 back to IDLE", busy, 0);

    // Test 2: 16 words, 10-cycle stall then full-rate release
    rx_q.delete();
    push_seq(8'h20, 16);
    repeat (2) step();
    m_ready = 1'b0;
    rd0 = rd_count;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 4) begin
        check("t2 stall m_valid", m_valid, 1);
        check("t2 stall m_data", m_data, 8'h20);
      end
    end
    check("t2 stall reads", rd_count - rd0, 3);
    check("t2 stall rd_en", fifo_rd_en, 0);
    m_ready = 1'b1;
    run_until("t2", 16, 60, used);
    check("t2 cycles for 16 words", used, 16);
    check_rx("t2", 8'h20, 16);
    enable = 1'b0;
    repeat (3) step();
    check("t2 words_out", words_out, 21);
    check("t2 words_out cnt4", words4, 5);

    // Test 3: random m_ready with a concurrent writer of 100 words
    rx_q.delete();
    wr_val   = 8'h40;
    wr_left  = 100;
    rnd_mode = 1'b1;
    enable   = 1'b1;
    run_until("t3", 100, 1000, used);
    check_rx("t3", 8'h40, 100);
    rnd_mode = 1'b0;
    m_ready  = 1'b0;
    enable   = 1'b0;
    repeat (3) step();
    check("t3 words_out", words_out, 121);
    check("t3 extra words", rx_q.size(), 100);

    // Test 4: flush with two words buffered and one in flight
    rx_q.delete();
    push_seq(8'h60, 6);
    repeat (2) step();
    rd0 = rd_count;
    enable = 1'b1;
    used = 0;
    while (!m_valid && used < 10) begin
      step();
      used++;
    end
    check("t4 m_valid rise", m_valid, 1);
    check("t4 cycles to m_valid", used, 4);
    check("t4 reads before flush", rd_count - rd0, 3);
    step();
    wo0 = words_out;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4 m_valid after flush", m_valid, 0);
    check("t4 rd_en after flush", fifo_rd_en, 0);
    check("t4 busy after flush", busy, 1);
    check("t4 words_out kept", words_out, wo0);
    m_ready = 1'b1;
    run_until("t4", 3, 30, used);
    check_rx("t4", 8'h63, 3);
    check("t4 words_out after", words_out, wo0 + 16'd3);
    enable = 1'b0;
    repeat (3) step();

    // Test 5: one-cycle reset mid-stream
    rx_q.delete();
    push_seq(8'h70, 8);
    repeat (2) step();
    enable = 1'b1;
    run_until("t5 pre", 2, 20, used);
    reset = 1'b0;
    step();
    check("t5 reset rd_en", fifo_rd_en, 0);
    check("t5 reset m_valid", m_valid, 0);
    check("t5 reset m_data", m_data, 0);
    check("t5 reset words_out", words_out, 0);
    check("t5 reset busy", busy, 0);
    check("t5 reset cnt4", words4, 0);
    reset = 1'b1;
    rx_q.delete();
    run_until("t5", 3, 30, used);
    check_rx("t5", 8'h75, 3);
    check("t5 words_out", words_out, 3);

    // Test 6: 17 words, narrow counter wraps 15 -> 0
    enable = 1'b0;
    reset  = 1'b0;
    step();
    reset = 1'b1;
    step();
    rx_q.delete();
    wrap_seen = 1'b0;
    push_seq(8'h80, 17);
    repeat (2) step();
    enable = 1'b1;
    run_until("t6", 17, 60, used);
    check_rx("t6", 8'h80, 17);
    step();
    check("t6 wrap seen", wrap_seen, 1);
    check("t6 cnt4 final", words4, 1);
    check("t6 words_out", words_out, 17);
    enable = 1'b0;
    repeat (4) step();
    check("t6 idle", busy, 0);
    check("read while empty", rd_viol, 0);
    check("shadow instance agrees", shadow_diff, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side controller for the team's synchronous FIFO (`fifo_sync`). It drains the FIFO through its `rd_en`/`dout`/`empty` port and presents the words as a valid/ready stream to a downstream consumer. A 3-entry output buffer absorbs the FIFO's one-cycle read latency and downstream back-pressure. `rd_en` is never asserted while the FIFO reports empty, so the block satisfies the FIFO's no-read-when-empty rule by construction.

## Interface
- `WIDTH`, 8: data width; must match the FIFO.
- `CNT_W`, 16: width of the delivered-word counter.
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `enable` in 1: permits new FIFO reads.
- `flush` in 1: discards buffered and in-flight words (one-cycle pulse).
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in WIDTH: FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en` out 1: FIFO read strobe; registered.
- `m_valid` out 1: output word available.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out WIDTH: output word.
- `words_out` out CNT_W: count of completed output handshakes; wraps modulo 2^CNT_W.
- `busy` out 1: high when not in IDLE.

## Operation
- State machine states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when `enable`=1.
  - RUN -> DRAIN when `enable`=0.
  - DRAIN -> RUN when `enable`=1.
  - DRAIN -> IDLE when in-flight=0 and occupancy=0.
- Internal state:
  - `inflight` (0..1): a read was issued last cycle and its data lands this cycle.
  - `occ` (0..3): number of words held in the output buffer.
- Read issue: `fifo_rd_en` is registered. Its next value is `state==RUN && enable && !fifo_empty && (occ_next + inflight_next) < 3`.
  - The term uses next-cycle values, so no combinational path runs from `m_ready` to `fifo_rd_en`.
- Capture: when `inflight`=1, `fifo_dout` is written into the buffer tail.
- Pop: a handshake (`m_valid && m_ready`) pops the head word.
  - Capture and pop in the same cycle leave `occ` unchanged.
- Output: `m_valid` = (`occ`>0). `m_data` = buffer head.
  - Once `m_valid` is high, `m_data` stays stable until the handshake completes.
- Word order is strictly FIFO order.
- Counter: `words_out` increments by 1 on each handshake and wraps from 2^CNT_W-1 to 0.
- Flush: in the flush cycle the block:
  - sets `occ` to 0;
  - marks any in-flight word for discard (its landing cycle does not capture);
  - forces `fifo_rd_en` to 0 next cycle;
  - goes to IDLE if `enable`=0, otherwise stays in RUN.
  - `words_out` is not cleared, and a handshake in the flush cycle is not counted.
- `fifo_empty` is taken as updated on the same edge as a read. `fifo_rd_en` is therefore never high in a cycle where `fifo_empty`=1.

## Timing
- Reset values (registered, one edge after `reset`=0 is sampled):
  - `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `words_out`=0, `busy`=0.
  - `occ`=0, `inflight`=0, state IDLE.
- Reset asserted mid-operation discards buffered and in-flight words. The FIFO contents are untouched.
- Latency from a non-empty FIFO with `enable` high and the block idle:
  - `fifo_rd_en` goes high 2 cycles after `enable` is sampled (IDLE->RUN edge, then the issue edge).
  - `m_valid` goes high 2 cycles after `fifo_rd_en`.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, one word per cycle is sustained.
- Back-pressure: with `m_ready`=0, at most 3 words are held. `fifo_rd_en` stops after the third outstanding read.
- `flush` and `reset` together: `reset` wins.
- `flush` and a handshake together: the handshake word is dropped and not counted.

## Test plan
- Prefill the FIFO with 5 words (0x11..0x15), hold `m_ready`=1, raise `enable`.
  - Expect exactly 5 handshakes in order 0x11..0x15.
  - Expect `words_out`=5, `fifo_rd_en` never high while `fifo_empty`=1, and a return to IDLE after `enable` drops.
- Prefill 16 words with `m_ready`=0 for 10 cycles, then `m_ready`=1.
  - During the stall, expect exactly 3 reads issued, `occ`=3, and `m_data`=word0 stable.
  - After release, expect all 16 words delivered in order.
- Toggle `m_ready` randomly for 200 cycles while a writer streams 100 words.
  - Expect no loss, no duplication, order preserved, and `words_out`=100.
- Pulse `flush` with `occ`=2 and one read in flight.
  - Expect `m_valid`=0 next cycle and the in-flight word not presented.
  - Expect delivery to resume with the next FIFO word, and `words_out` unchanged by the flush.
- Assert `reset`=0 mid-stream for 1 cycle.
  - Expect all outputs at their reset values and the read stream restarting from the FIFO head after `enable`.
- With `CNT_W`=4, deliver 17 words.
  - Expect `words_out` to wrap 15->0 and end at 1.
